// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Constants and types shared by the I2S transmit and receive directions.
//   I2S_SAMPLE_W   : default audio sample width in bits
//   I2S_BCK_DIV    : system clocks per BCK period used by the transmitter
//   i2s_rx_state_t : receiver word-framing state
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int I2S_SAMPLE_W = 24;
  localparam int I2S_BCK_DIV  = 26;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,  // waiting for the first word boundary after reset
    SHIFT = 1'b1   // collecting bits of the current half-frame
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge
// Brings one asynchronous pad signal into the clk domain through a
// SYNC_STAGES flop chain and flags its rising edge.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   i_async  : pad-level input, asynchronous to clk
//   o_level  : synchronised level
//   o_rise   : one-clk registered pulse, one clk after o_level goes 0 -> 1
// ---------------------------------------------------------------------------
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the value its
      // predecessor held before this edge; blocking ones would collapse the
      // chain into a single flop.
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_rise;

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// I2S receiver. Synchronises BCK/WS/SD into the clk domain, recovers
// MSB-first left/right words with the standard one-BCK WS delay and presents
// them on a valid/ready port. clk must run at least 8x the BCK rate.
//   clk, rst       : system clock, asynchronous active-high reset
//   bck, ws, sd    : I2S pad inputs, asynchronous to clk
//   invert         : static; swaps the meaning of ws
//   sample_out     : received word, left-justified, zero-padded if short
//   sample_right   : 1 = right channel word, 0 = left
//   sample_valid   : word available; held until sample_ready
//   sample_ready   : consumer accepts the word
//   overrun        : sticky, a held word was overwritten
//   frame_err      : (only with I2S_RX_FRAME_CHECK_EN) one-clk pulse with an
//                    emitted word whose half-frame was not SAMPLE_W bits
// Build option: define I2S_RX_FRAME_CHECK_EN to add frame_err.
// ---------------------------------------------------------------------------
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = I2S_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bck,
  input  logic                ws,
  input  logic                sd,
  input  logic                invert,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic                frame_err
`endif
);

  localparam int             CNT_W    = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W);

  // Synchronised pad signals
  logic w_bck_rise;
  logic w_bck_level_unused;
  logic w_ws_level;
  logic w_ws_rise_unused;
  logic w_sd_level;
  logic w_sd_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
    .clk     (clk),
    .rst     (rst),
    .i_async (bck),
    .o_level (w_bck_level_unused),
    .o_rise  (w_bck_rise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
    .clk     (clk),
    .rst     (rst),
    .i_async (ws),
    .o_level (w_ws_level),
    .o_rise  (w_ws_rise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .clk     (clk),
    .rst     (rst),
    .i_async (sd),
    .o_level (w_sd_level),
    .o_rise  (w_sd_rise_unused)
  );

  // Framing state
  i2s_rx_state_t       r_state;
  logic                r_ws_prev;
  logic [SAMPLE_W-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;

  // Output port registers
  logic [SAMPLE_W-1:0] r_sample_out;
  logic                r_sample_right;
  logic                r_sample_valid;
  logic                r_overrun;

  logic                w_ws_s;
  logic                w_ws_change;
  logic                w_has_room;
  logic                w_emit;
  logic [SAMPLE_W-1:0] w_shift_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [SAMPLE_W-1:0] w_word;

  assign w_ws_s      = w_ws_level ^ invert;
  assign w_ws_change = w_bck_rise && (w_ws_s != r_ws_prev);
  assign w_has_room  = (r_bit_cnt < FULL_CNT);
  assign w_emit      = (r_state == SHIFT) && w_ws_change;

  // Shift register and count after taking this edge's bit; bits past
  // SAMPLE_W are dropped so the register always holds the leading bits.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch
    // is inferred.
    w_shift_next = r_shift;
    w_cnt_next   = r_bit_cnt;
    if (w_has_room) begin
      w_shift_next = {r_shift[SAMPLE_W-2:0], w_sd_level};
      w_cnt_next   = r_bit_cnt + CNT_W'(1);
    end
  end

  // Short half-frames are left-justified: shift up by the missing bit count.
  assign w_word = w_shift_next << (FULL_CNT - w_cnt_next);

`ifdef I2S_RX_FRAME_CHECK_EN
  logic r_long;       // a bit was dropped in the current half-frame
  logic r_frame_err;
  logic w_len_err;

  assign w_len_err = (w_cnt_next != FULL_CNT) || r_long || !w_has_room;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ws_prev      <= 1'b0;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_sample_out   <= '0;
      r_sample_right <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      r_long         <= 1'b0;
      r_frame_err    <= 1'b0;
`endif
    end else begin
`ifdef I2S_RX_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
      if (w_bck_rise) begin
        r_ws_prev <= w_ws_s;
        case (r_state)
          IDLE: begin
            if (w_ws_change) begin
              r_state   <= SHIFT;
              r_shift   <= '0;
              r_bit_cnt <= '0;
`ifdef I2S_RX_FRAME_CHECK_EN
              r_long    <= 1'b0;
`endif
            end
          end
          SHIFT: begin
            if (w_ws_change) begin
              // Word boundary: the final bit goes straight into w_word.
              r_shift   <= '0;
              r_bit_cnt <= '0;
`ifdef I2S_RX_FRAME_CHECK_EN
              r_long    <= 1'b0;
`endif
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= w_cnt_next;
`ifdef I2S_RX_FRAME_CHECK_EN
              if (!w_has_room) r_long <= 1'b1;
`endif
            end
          end
          default: r_state <= IDLE;
        endcase
      end

      // A new word always wins; an accept in the same clk is not an overrun.
      if (w_emit) begin
        r_sample_out   <= w_word;
        r_sample_right <= r_ws_prev;
        r_sample_valid <= 1'b1;
        if (r_sample_valid && !sample_ready) r_overrun <= 1'b1;
`ifdef I2S_RX_FRAME_CHECK_EN
        r_frame_err    <= w_len_err;
`endif
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;
`ifdef I2S_RX_FRAME_CHECK_EN
  assign frame_err    = r_frame_err;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
// Self-checking bench for i2s_rx. A transmitter model turns a list of words
// into a BCK/WS/SD pad stream; received words are collected at the port and
// compared with hand-written table values or with a word-level model.
// Build option: I2S_RX_FRAME_CHECK_EN adds frame_err checks.
// ---------------------------------------------------------------------------
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int W    = I2S_SAMPLE_W;
  localparam int HALF = I2S_BCK_DIV / 2;

  logic         clk;
  logic         rst;
  logic         bck;
  logic         ws;
  logic         sd;
  logic         invert;
  logic [W-1:0] sample_out;
  logic         sample_right;
  logic         sample_valid;
  logic         sample_ready;
  logic         overrun;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic         frame_err;
`endif

  i2s_rx #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bck          (bck),
    .ws           (ws),
    .sd           (sd),
    .invert       (invert),
    .sample_out   (sample_out),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err    (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic [31:0] data;
    int          nbits;
  } word_t;

  typedef struct {
    logic [W-1:0] data;
    logic         right;
    logic         ferr;
  } samp_t;

  typedef struct {
    logic         ch;
    logic [31:0]  data;
    int           nbits;
    logic [W-1:0] exp_data;
    logic         exp_right;
    logic         exp_ferr;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  word_t      words[$];
  logic [1:0] bq[$];      // {ws, sd} per BCK period
  samp_t      exp_q[$];
  samp_t      got_q[$];
  logic       mon_en = 1'b0;
  vec_t       tbl[8];

  // Collect every accepted word.
  always @(negedge clk) begin
    if (mon_en && !rst && sample_valid && sample_ready) begin
      samp_t s;
      s.data  = sample_out;
      s.right = sample_right;
`ifdef I2S_RX_FRAME_CHECK_EN
      s.ferr  = frame_err;
`else
      s.ferr  = 1'b0;
`endif
      got_q.push_back(s);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Falling half of a BCK period: set ws/sd, hold BCK low. Ends on a posedge.
  task automatic send_bit_lo(input logic w, input logic d);
    @(posedge clk);
    #1;
    bck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_bit(input logic w, input logic d);
    send_bit_lo(w, d);
    #1 bck = 1'b1;
    repeat (HALF - 1) @(posedge clk);
  endtask

  task automatic play_n(input int n);
    logic [1:0] b;
    for (int i = 0; i < n; i++) begin
      if (bq.size() > 0) begin
        b = bq.pop_front();
        send_bit(b[1], b[0]);
      end
    end
  endtask

  // I2S framing: WS switches together with the LSB of the ending word.
  task automatic build_stream();
    logic nch;
    bq.delete();
    for (int k = 0; k < words.size(); k++) begin
      for (int i = words[k].nbits - 1; i >= 1; i--)
        bq.push_back({words[k].ch, words[k].data[i]});
      nch = (k + 1 < words.size()) ? words[k+1].ch : words[k].ch;
      bq.push_back({nch, words[k].data[0]});
    end
  endtask

  // First W bits received, MSB-first, left-justified.
  function automatic logic [W-1:0] justify(input logic [31:0] d, input int n);
    logic [31:0] t;
    if (n >= W) t = d >> (n - W);
    else        t = d << (W - n);
    return t[W-1:0];
  endfunction

  // The leading word only opens the first frame and the last word never
  // sees a closing WS change, so only the words in between are received.
  task automatic ref_model(input logic inv);
    samp_t s;
    exp_q.delete();
    for (int k = 1; k + 1 < words.size(); k++) begin
      s.data  = justify(words[k].data, words[k].nbits);
      s.right = words[k].ch ^ inv;
      s.ferr  = (words[k].nbits != W);
      exp_q.push_back(s);
    end
  endtask

  task automatic run_stream();
    build_stream();
    got_q.delete();
    mon_en = 1'b1;
    play_n(bq.size());
    repeat (8) @(posedge clk);
    mon_en = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d] data", tag, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s[%0d] right", tag, i), got_q[i].right, exp_q[i].right);
`ifdef I2S_RX_FRAME_CHECK_EN
      check($sformatf("%s[%0d] frame_err", tag, i), got_q[i].ferr, exp_q[i].ferr);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [1:0]  b;
    logic [31:0] rd;
    int          nb;

    rst          = 1'b1;
    invert       = 1'b0;
    sample_ready = 1'b1;

    tbl[0] = '{1'b1, 32'h5A5A5A,   24, 24'h5A5A5A, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 32'hA5A5A5,   24, 24'hA5A5A5, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h5A5A5A,   24, 24'h5A5A5A, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'hFFFFF,    20, 24'hFFFFF0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h800001,   24, 24'h800001, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'hABCDEF1,  28, 24'hABCDEF, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 32'h3,         2, 24'hC00000, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 32'h000001,   24, 24'h000001, 1'b0, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset sample_out", sample_out, 0);
    check("reset sample_right", sample_right, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset overrun", overrun, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("reset frame_err", frame_err, 0);
`endif

    // Table vectors, ready tied high, leading partial word discarded
    words.delete();
    words.push_back('{1'b0, 32'h111111, 24});
    for (int i = 0; i < 8; i++) words.push_back('{tbl[i].ch, tbl[i].data, tbl[i].nbits});
    words.push_back('{1'b1, 32'h222222, 24});
    run_stream();
    check("table count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check($sformatf("table[%0d] data", i), got_q[i].data, tbl[i].exp_data);
      check($sformatf("table[%0d] right", i), got_q[i].right, tbl[i].exp_right);
`ifdef I2S_RX_FRAME_CHECK_EN
      check($sformatf("table[%0d] frame_err", i), got_q[i].ferr, tbl[i].exp_ferr);
`endif
    end
    check("table overrun", overrun, 0);

    // Inverted word select: same data, channels swapped
    invert = 1'b1;
    do_reset();
    words.delete();
    words.push_back('{1'b1, 32'h5A5A5A, 24});
    words.push_back('{1'b0, 32'hA5A5A5, 24});
    words.push_back('{1'b1, 32'h5A5A5A, 24});
    words.push_back('{1'b0, 32'hA5A5A5, 24});
    words.push_back('{1'b1, 32'h5A5A5A, 24});
    ref_model(1'b1);
    run_stream();
    compare_model("invert");
    invert = 1'b0;

    // Random words and lengths against the word-level model
    do_reset();
    words.delete();
    for (int k = 0; k < 10; k++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 30)) : W;
      rd = $urandom() & ((32'h1 << nb) - 32'h1);
      words.push_back('{k[0], rd, nb});
    end
    ref_model(1'b0);
    run_stream();
    compare_model("random");

    // Overrun: ready held low across two emits
    do_reset();
    sample_ready = 1'b0;
    words.delete();
    words.push_back('{1'b0, 32'h111111, 24});
    words.push_back('{1'b1, 32'h123456, 24});
    words.push_back('{1'b0, 32'h654321, 24});
    words.push_back('{1'b1, 32'h0F0F0F, 24});
    build_stream();
    play_n(48);
    @(negedge clk);
    check("ovr first valid", sample_valid, 1);
    check("ovr first data", sample_out, 32'h123456);
    check("ovr first right", sample_right, 1);
    check("ovr first overrun", overrun, 0);
    play_n(24);
    @(negedge clk);
    check("ovr second valid", sample_valid, 1);
    check("ovr second data", sample_out, 32'h654321);
    check("ovr second right", sample_right, 0);
    check("ovr second overrun", overrun, 1);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("ovr frame_err idle", frame_err, 0);
`endif
    sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr accepted valid", sample_valid, 0);
    check("ovr sticky", overrun, 1);
    bq.delete();

    // Accept in the same clk as a new emit
    do_reset();
    sample_ready = 1'b0;
    words.delete();
    words.push_back('{1'b0, 32'h111111, 24});
    words.push_back('{1'b1, 32'h13579B, 24});
    words.push_back('{1'b0, 32'h2468AC, 24});
    words.push_back('{1'b1, 32'h0F0F0F, 24});
    build_stream();
    play_n(48);
    @(negedge clk);
    check("same first valid", sample_valid, 1);
    check("same first data", sample_out, 32'h13579B);
    play_n(23);
    b = bq.pop_front();
    send_bit_lo(b[1], b[0]);
    #1 bck = 1'b1;               // pad edge carrying the WS change
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("same held data", sample_out, 32'h13579B);
    @(posedge clk);
    #1 sample_ready = 1'b1;      // high only for the emit edge
    @(posedge clk);
    @(negedge clk);
    check("same new data", sample_out, 32'h2468AC);
    check("same new right", sample_right, 0);
    check("same valid kept", sample_valid, 1);
    check("same no overrun", overrun, 0);
    @(posedge clk);
    @(negedge clk);
    check("same accepted", sample_valid, 0);
    bq.delete();

    // Reset at bit 12 of a word
    do_reset();
    sample_ready = 1'b0;
    words.delete();
    words.push_back('{1'b0, 32'h111111, 24});
    words.push_back('{1'b1, 32'h2A2A2A, 24});
    words.push_back('{1'b0, 32'h333333, 24});
    words.push_back('{1'b1, 32'hC3C3C3, 24});
    words.push_back('{1'b0, 32'h444444, 24});
    build_stream();
    play_n(24 + 24 + 12);
    @(negedge clk);
    check("rst pre valid", sample_valid, 1);
    check("rst pre right", sample_right, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid sample_out", sample_out, 0);
    check("rst mid sample_right", sample_right, 0);
    check("rst mid sample_valid", sample_valid, 0);
    check("rst mid overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    sample_ready = 1'b1;
    mon_en = 1'b1;
    play_n(bq.size());
    repeat (8) @(posedge clk);
    mon_en = 1'b0;
    check("rst count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      check("rst word data", got_q[0].data, 32'hC3C3C3);
      check("rst word right", got_q[0].right, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
